usb_rx_phy: RTL

Full-speed USB receive front end: turns the raw D+/D- pins into a stream of validated bytes with packet framing. Clocked at 48 MHz, so there are 4 samples per 12 Mb/s bit. It performs synchronisation, clock recovery, NRZI decode, bit unstuffing, SYNC/EOP detection and bus-reset detection. It sits directly upstream of the transaction state machine, which consumes its byte/EOP/error strobes.

---
 rtl/usb_rx_phy.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_phy.sv
// Full-speed USB receive front end: pin synchroniser, 4x oversampled clock recovery,
// NRZI decode, bit unstuffing, SYNC/EOP framing and bus-reset detection.
module usb_rx_phy #(
  parameter int RESET_SE0_CYCLES = 120
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic       dp_in,
  input  logic       dn_in,
  input  logic       rx_enable,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       bus_reset
);

  localparam int CNT_W = $clog2(RESET_SE0_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_SE0_CYCLES);

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERR} state_t;

  logic [1:0]       sync1_reg, line_reg, prev_line_reg;
  logic [1:0]       phase_reg, phase_now;
  logic             bit_strobe, bit_one;
  state_t           state_reg, state_next;
  logic [1:0]       last_sample_reg, last_sample_next;
  logic [1:0]       zero_cnt_reg, zero_cnt_next;
  logic [2:0]       ones_cnt_reg, ones_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       byte_reg, byte_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             eop_reg, eop_next;
  logic             error_reg, error_next;
  logic             active_reg, active_next;
  logic             err_se0_reg, err_se0_next;
  logic [2:0]       err_j_cnt_reg, err_j_cnt_next;
  logic [CNT_W-1:0] se0_cnt_reg, se0_cnt_next;
  logic             bus_reset_reg, bus_reset_next;

  // Phase restarts on every line transition, so the strobe lands mid-bit even with jitter.
  assign phase_now  = (line_reg != prev_line_reg) ? 2'd0 : phase_reg + 2'd1;
  assign bit_strobe = (phase_now == 2'd2);
  assign bit_one    = (line_reg == last_sample_reg);

  always_comb begin
    state_next       = state_reg;
    last_sample_next = last_sample_reg;
    zero_cnt_next    = zero_cnt_reg;
    ones_cnt_next    = ones_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    byte_next        = byte_reg;
    byte_valid_next  = 1'b0;
    eop_next         = 1'b0;
    error_next       = 1'b0;
    err_se0_next     = (state_reg == ST_ERR) ? err_se0_reg : 1'b0;
    err_j_cnt_next   = (state_reg == ST_ERR) ? err_j_cnt_reg : 3'd0;

    if (!rx_enable) begin
      state_next       = ST_IDLE;
      last_sample_next = LS_J;
    end else if (bit_strobe) begin
      unique case (state_reg)
        ST_IDLE: begin
          last_sample_next = LS_J;
          if (line_reg == LS_K) begin
            state_next       = ST_SYNC;
            zero_cnt_next    = 2'd1;
            last_sample_next = LS_K;
          end
        end
        ST_SYNC: begin
          last_sample_next = line_reg;
          if (line_reg == LS_SE0 || line_reg == LS_SE1) begin
            state_next       = ST_IDLE;
            last_sample_next = LS_J;
          end else if (!bit_one) begin
            if (zero_cnt_reg != 2'd3) zero_cnt_next = zero_cnt_reg + 2'd1;
          end else if (zero_cnt_reg == 2'd3) begin
            state_next    = ST_DATA;
            ones_cnt_next = 3'd1;
            bit_cnt_next  = 3'd0;
          end else begin
            state_next = ST_ERR;
            error_next = 1'b1;
          end
        end
        ST_DATA: begin
          if (line_reg == LS_SE0) begin
            state_next = ST_EOP;
          end else if (line_reg == LS_SE1) begin
            state_next = ST_ERR;
            error_next = 1'b1;
          end else begin
            last_sample_next = line_reg;
            if (ones_cnt_reg == 3'd6) begin
              // Stuff bit: must be a zero and is dropped from the data stream.
              if (bit_one) begin
                state_next = ST_ERR;
                error_next = 1'b1;
              end
              ones_cnt_next = 3'd0;
            end else begin
              ones_cnt_next = bit_one ? ones_cnt_reg + 3'd1 : 3'd0;
              shift_next    = {bit_one, shift_reg[7:1]};
              bit_cnt_next  = bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                byte_next       = shift_next;
                byte_valid_next = 1'b1;
              end
            end
          end
        end
        ST_EOP: begin
          if (line_reg == LS_J) begin
            state_next       = ST_IDLE;
            last_sample_next = LS_J;
            eop_next         = 1'b1;
            error_next       = (bit_cnt_reg != 3'd0);
          end else if (line_reg != LS_SE0) begin
            state_next = ST_ERR;
            error_next = 1'b1;
          end
        end
        ST_ERR: begin
          if (line_reg == LS_SE0) begin
            err_se0_next   = 1'b1;
            err_j_cnt_next = 3'd0;
          end else if (line_reg == LS_J) begin
            err_j_cnt_next = err_j_cnt_reg + 3'd1;
            if (err_se0_reg || err_j_cnt_reg == 3'd7) begin
              state_next       = ST_IDLE;
              last_sample_next = LS_J;
            end
          end else begin
            err_se0_next   = 1'b0;
            err_j_cnt_next = 3'd0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Held through the rx_eop cycle so the consumer sees the EOP inside the packet window.
    active_next = (state_next == ST_DATA) || (state_next == ST_EOP) || eop_next;
  end

  always_comb begin
    se0_cnt_next = se0_cnt_reg;
    if (line_reg != LS_SE0)
      se0_cnt_next = '0;
    else if (se0_cnt_reg != CNT_MAX)
      se0_cnt_next = se0_cnt_reg + 1'b1;
    bus_reset_next = (line_reg == LS_SE0) && (se0_cnt_reg >= CNT_MAX);
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      sync1_reg       <= LS_J;
      line_reg        <= LS_J;
      prev_line_reg   <= LS_J;
      phase_reg       <= 2'd0;
      state_reg       <= ST_IDLE;
      last_sample_reg <= LS_J;
      zero_cnt_reg    <= 2'd0;
      ones_cnt_reg    <= 3'd0;
      bit_cnt_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      byte_reg        <= 8'h00;
      byte_valid_reg  <= 1'b0;
      eop_reg         <= 1'b0;
      error_reg       <= 1'b0;
      active_reg      <= 1'b0;
      err_se0_reg     <= 1'b0;
      err_j_cnt_reg   <= 3'd0;
      se0_cnt_reg     <= '0;
      bus_reset_reg   <= 1'b0;
    end else begin
      sync1_reg       <= {dp_in, dn_in};
      line_reg        <= sync1_reg;
      prev_line_reg   <= line_reg;
      phase_reg       <= phase_now;
      state_reg       <= state_next;
      last_sample_reg <= last_sample_next;
      zero_cnt_reg    <= zero_cnt_next;
      ones_cnt_reg    <= ones_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      byte_reg        <= byte_next;
      byte_valid_reg  <= byte_valid_next;
      eop_reg         <= eop_next;
      error_reg       <= error_next;
      active_reg      <= active_next;
      err_se0_reg     <= err_se0_next;
      err_j_cnt_reg   <= err_j_cnt_next;
      se0_cnt_reg     <= se0_cnt_next;
      bus_reset_reg   <= bus_reset_next;
    end
  end

  assign line_state    = line_reg;
  assign rx_active     = active_reg;
  assign rx_byte       = byte_reg;
  assign rx_byte_valid = byte_valid_reg;
  assign rx_eop        = eop_reg;
  assign rx_error      = error_reg;
  assign bus_reset     = bus_reset_reg;

endmodule
